// File: rtl/dh_pkg.sv
// rtl/dh_pkg.sv - shared width, FSM encoding and latency helper for the Diffie-Hellman datapath
// Used by mod_exp_engine (optional feature macro: MODEXP_CONST_TIME_EN).
package dh_pkg;

  localparam int DH_WIDTH  = 32;
  localparam int MM_CYCLES = DH_WIDTH + 2;

  typedef enum logic [2:0] {
    MX_IDLE   = 3'd0,
    MX_LOAD   = 3'd1,
    MX_REDUCE = 3'd2,
    MX_SQUARE = 3'd3,
    MX_MULT   = 3'd4,
    MX_NEXT   = 3'd5,
    MX_FINISH = 3'd6
  } modexp_state_t;

  // Cycles from the accepting edge to DONE; trivial covers MOD of 0 or 1.
  function automatic int modexp_latency(input int width, input int mults, input bit trivial);
    if (trivial) begin
      return 2;
    end
    return 2 + (width + 2) * (1 + width + mults);
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// rtl/mod_mul_serial.sv - bit-serial interleaved modular multiplier, p = a*b mod m
// One launch edge, WIDTH iteration edges, then done pulses for one cycle; requires a < m.
module mod_mul_serial
  import dh_pkg::*;
#(
  parameter int WIDTH = DH_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_red1;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_red2;

  // One extra bit keeps 2R and R+a exact for any modulus up to 2^WIDTH-1.
  always_comb begin
    w_m_ext = {1'b0, r_m};
    w_dbl   = r_r << 1;
    w_red1  = (w_dbl >= w_m_ext) ? (w_dbl - w_m_ext) : w_dbl;
    w_add   = r_b[WIDTH-1] ? (w_red1 + {1'b0, r_a}) : w_red1;
    w_red2  = (w_add >= w_m_ext) ? (w_add - w_m_ext) : w_add;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_r    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start && !r_busy) begin
        r_r    <= '0;
        r_a    <= a;
        r_b    <= b;
        r_m    <= m;
        r_cnt  <= CW'(WIDTH - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_r <= w_red2;
        r_b <= r_b << 1;
        if (r_cnt == '0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign done = r_done;
  assign p    = r_r[WIDTH-1:0];

endmodule

// File: rtl/mod_exp_engine.sv
// rtl/mod_exp_engine.sv - left-to-right square-and-multiply RESULT = BASE^EXP mod MOD
// Define MODEXP_CONST_TIME_EN to run a MULT on every exponent bit (data-independent latency).
module mod_exp_engine
  import dh_pkg::*;
#(
  parameter int WIDTH = DH_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] BASE,
  input  logic [WIDTH-1:0] EXP,
  input  logic [WIDTH-1:0] MOD,
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [WIDTH-1:0] RESULT
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = MX_IDLE;
  localparam logic [2:0] S_LOAD   = MX_LOAD;
  localparam logic [2:0] S_REDUCE = MX_REDUCE;
  localparam logic [2:0] S_SQUARE = MX_SQUARE;
  localparam logic [2:0] S_MULT   = MX_MULT;
  localparam logic [2:0] S_FINISH = MX_FINISH;

  logic [2:0]       r_state;
  logic             r_launched;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_mod;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [IW-1:0]    r_idx;
  logic             r_err;
  logic             r_done;

  logic             w_ready;
  logic             w_op_state;
  logic             w_mm_start;
  logic             w_mm_done;
  logic             w_bit;
  logic             w_last_bit;
  logic             w_do_mult;
  logic [WIDTH-1:0] w_mm_a;
  logic [WIDTH-1:0] w_mm_b;
  logic [WIDTH-1:0] w_mm_p;

  // DONE cycle still reads as busy so READY reappears one cycle later.
  assign w_ready    = (r_state == S_IDLE) && !r_done;
  assign w_op_state = (r_state == S_REDUCE) || (r_state == S_SQUARE) || (r_state == S_MULT);
  assign w_mm_start = w_op_state && !r_launched;
  assign w_bit      = r_exp[r_idx];
  assign w_last_bit = (r_idx == '0);

`ifdef MODEXP_CONST_TIME_EN
  assign w_do_mult = 1'b1;
`else
  assign w_do_mult = w_bit;
`endif

  always_comb begin
    w_mm_a = r_acc;
    w_mm_b = r_acc;
    case (r_state)
      S_REDUCE: begin
        w_mm_a = WIDTH'(1);
        w_mm_b = r_base;
      end
      S_MULT: begin
        w_mm_b = r_b;
      end
      default: begin
      end
    endcase
  end

  mod_mul_serial #(
    .WIDTH(WIDTH)
  ) u_mod_mul (
    .CLK  (CLK),
    .RST  (RST),
    .start(w_mm_start),
    .a    (w_mm_a),
    .b    (w_mm_b),
    .m    (r_mod),
    .done (w_mm_done),
    .p    (w_mm_p)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_launched <= 1'b0;
      r_base     <= '0;
      r_exp      <= '0;
      r_mod      <= '0;
      r_acc      <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_idx      <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START && w_ready) begin
            r_base  <= BASE;
            r_exp   <= EXP;
            r_mod   <= MOD;
            r_err   <= 1'b0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_mod == '0) begin
            r_err   <= 1'b1;
            r_acc   <= '0;
            r_state <= S_FINISH;
          end else if (r_mod == WIDTH'(1)) begin
            r_acc   <= '0;
            r_state <= S_FINISH;
          end else begin
            r_acc   <= WIDTH'(1);
            r_idx   <= IW'(WIDTH - 1);
            r_state <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          if (!r_launched) begin
            r_launched <= 1'b1;
          end else if (w_mm_done) begin
            r_b        <= w_mm_p;
            r_launched <= 1'b0;
            r_state    <= S_SQUARE;
          end
        end
        // The bit-step decision is folded into the capture edge of each op.
        S_SQUARE: begin
          if (!r_launched) begin
            r_launched <= 1'b1;
          end else if (w_mm_done) begin
            r_acc      <= w_mm_p;
            r_launched <= 1'b0;
            if (w_do_mult) begin
              r_state <= S_MULT;
            end else if (w_last_bit) begin
              r_state <= S_FINISH;
            end else begin
              r_idx   <= r_idx - IW'(1);
              r_state <= S_SQUARE;
            end
          end
        end
        S_MULT: begin
          if (!r_launched) begin
            r_launched <= 1'b1;
          end else if (w_mm_done) begin
            r_acc      <= w_bit ? w_mm_p : r_acc;
            r_launched <= 1'b0;
            if (w_last_bit) begin
              r_state <= S_FINISH;
            end else begin
              r_idx   <= r_idx - IW'(1);
              r_state <= S_SQUARE;
            end
          end
        end
        S_FINISH: begin
          r_result <= r_acc;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign READY  = w_ready;
  assign BUSY   = ~w_ready;
  assign DONE   = r_done;
  assign ERR    = r_err;
  assign RESULT = r_result;

endmodule

// File: tb/tb_mod_exp_engine.sv
// tb/tb_mod_exp_engine.sv - directed self-checking bench for mod_exp_engine
`timescale 1ns/1ps
module tb_mod_exp_engine;
  import dh_pkg::*;

  localparam int W = DH_WIDTH;
`ifdef MODEXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [W-1:0] BASE;
  logic [W-1:0] EXP;
  logic [W-1:0] MOD;
  logic         READY;
  logic         BUSY;
  logic         DONE;
  logic         ERR;
  logic [W-1:0] RESULT;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] prev_result;

  always #5 CLK = ~CLK;

  mod_exp_engine #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .BASE  (BASE),
    .EXP   (EXP),
    .MOD   (MOD),
    .READY (READY),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERR   (ERR),
    .RESULT(RESULT)
  );

  function automatic int lat(input int plain);
    return CT ? 2212 : plain;
  endfunction

  // Called at a negedge with READY=1; returns at the negedge where READY is back.
  task automatic run_req(input string name, input logic [W-1:0] b, input logic [W-1:0] e,
                         input logic [W-1:0] m, input logic [W-1:0] exp_res, input logic exp_err,
                         input int exp_lat, input int poke_at);
    int n;
    START = 1'b1; BASE = b; EXP = e; MOD = m;
    @(negedge CLK);
    START = 1'b0; BASE = $urandom; EXP = $urandom; MOD = $urandom;
    n = 0;
    checks++;
    if (READY !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: READY=%b BUSY=%b, want READY=0 BUSY=1", name, READY, BUSY);
    end
    checks++;
    if (ERR !== 1'b0 || RESULT !== prev_result) begin
      errors++;
      $display("FAIL %s hold: ERR=%b RESULT=%h, want ERR=0 RESULT=%h", name, ERR, RESULT, prev_result);
    end
    while (DONE !== 1'b1 && n < exp_lat + 40) begin
      if (n == poke_at) begin
        START = 1'b1; BASE = 32'd5; EXP = 32'd6; MOD = 32'd23;
      end
      @(negedge CLK);
      n++;
      START = 1'b0;
    end
    checks++;
    if (n !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, n, exp_lat);
    end
    checks++;
    if (RESULT !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h, want %h", name, RESULT, exp_res);
    end
    checks++;
    if (ERR !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b, want %b", name, ERR, exp_err);
    end
    checks++;
    if (READY !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_on_done: got %b, want 0", name, READY);
    end
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b0 || READY !== 1'b1 || RESULT !== exp_res) begin
      errors++;
      $display("FAIL %s after_done: DONE=%b READY=%b RESULT=%h, want 0 1 %h", name, DONE, READY, RESULT, exp_res);
    end
    prev_result = exp_res;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; BASE = '0; EXP = '0; MOD = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if (READY !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0 || RESULT !== '0) begin
      errors++;
      $display("FAIL reset: READY=%b BUSY=%b DONE=%b ERR=%b RESULT=%h, want 1 0 0 0 0", READY, BUSY, DONE, ERR, RESULT);
    end
    RST = 1'b0;
    @(negedge CLK);
    prev_result = '0;
  endtask

  task automatic test_arith();
    run_req("basic_5_6_23", 32'd5, 32'd6, 32'd23, 32'd8, 1'b0, lat(1192), -1);
    run_req("exp_zero", 32'd7, 32'd0, 32'd13, 32'd1, 1'b0, lat(1124), -1);
    run_req("base_reduce", 32'd100, 32'd1, 32'd7, 32'd2, 1'b0, lat(1158), -1);
    run_req("full_width", 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd32, 1'b0, lat(2212), -1);
  endtask

  task automatic test_trivial_mod();
    run_req("mod_zero", 32'd9, 32'd3, 32'd0, 32'd0, 1'b1, 2, -1);
    run_req("mod_one", 32'd9, 32'd3, 32'd1, 32'd0, 1'b0, 2, -1);
    run_req("mod_zero_again", 32'd4, 32'd4, 32'd0, 32'd0, 1'b1, 2, -1);
    run_req("err_clear", 32'd5, 32'd6, 32'd23, 32'd8, 1'b0, lat(1192), -1);
  endtask

  task automatic test_busy_ignore();
    run_req("busy_ignore", 32'd100, 32'd1, 32'd7, 32'd2, 1'b0, lat(1158), 100);
  endtask

  task automatic test_reset_mid();
    bit seen;
    START = 1'b1; BASE = 32'd5; EXP = 32'd6; MOD = 32'd23;
    @(negedge CLK);
    START = 1'b0;
    repeat (500) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (READY !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0 || RESULT !== '0) begin
      errors++;
      $display("FAIL mid_reset: READY=%b BUSY=%b DONE=%b ERR=%b RESULT=%h, want 1 0 0 0 0", READY, BUSY, DONE, ERR, RESULT);
    end
    RST = 1'b0;
    seen = 1'b0;
    repeat (800) begin
      @(negedge CLK);
      if (DONE !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL aborted_done: DONE seen=%b, want 0", seen);
    end
    prev_result = '0;
    run_req("after_reset", 32'd5, 32'd6, 32'd23, 32'd8, 1'b0, lat(1192), -1);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_trivial_mod();
    test_busy_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
